// File: rtl/input_pio_pkg.sv
// Shared register map and edge-type encoding for the debounced input PIO.
package input_pio_pkg;

  localparam logic [1:0] ADDR_DATA     = 2'd0;
  localparam logic [1:0] ADDR_IRQ_MASK = 2'd1;
  localparam logic [1:0] ADDR_EDGE_CAP = 2'd2;
  localparam logic [1:0] ADDR_RAW      = 2'd3;

  typedef enum logic [1:0] {
    EDGE_RISE = 2'd0,
    EDGE_FALL = 2'd1,
    EDGE_ANY  = 2'd2
  } edge_type_e;

endpackage

// File: rtl/input_debounce.sv
// One input bit: two-flop synchroniser followed by a run-length debouncer;
// the stable output only moves once sync has disagreed for DEBOUNCE_CYCLES samples.
module input_debounce #(
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pin_i,
  output logic sync_o,
  output logic stable_o
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             meta_q,   meta_d;
  logic             sync_q,   sync_d;
  logic             stable_q, stable_d;
  logic [CNT_W-1:0] cnt_q,    cnt_d;

  // Any sample agreeing with stable drops the counter back to zero.
  always_comb begin
    meta_d   = pin_i;
    sync_d   = meta_q;
    stable_d = stable_q;
    cnt_d    = '0;
    if (sync_q != stable_q) begin
      if (cnt_q == CNT_LAST) begin
        stable_d = sync_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q   <= 1'b0;
      sync_q   <= 1'b0;
      stable_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      meta_q   <= meta_d;
      sync_q   <= sync_d;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  assign sync_o   = sync_q;
  assign stable_o = stable_q;

endmodule

// File: rtl/input_pio_debounce.sv
// Avalon-MM input PIO with per-bit debounce, edge capture and level irq.
// Edge capture, IRQ mask and irq exist only when INPUT_PIO_EDGE_IRQ_EN is defined.
module input_pio_debounce
  import input_pio_pkg::*;
#(
  parameter int WIDTH           = 10,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int EDGE_TYPE       = 0
) (
  input  logic             clk50,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] pins_in,
  input  logic [1:0]       avs_address,
  input  logic             avs_read,
  input  logic             avs_write,
  input  logic [31:0]      avs_writedata,
  output logic [31:0]      avs_readdata,
  output logic             irq
);

  logic [WIDTH-1:0] sync_w;
  logic [WIDTH-1:0] stable_w;
  logic [31:0]      readdata_q, readdata_d;
  logic             unused_bus;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    input_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db (
      .clk     (clk50),
      .rst_n   (reset_n),
      .pin_i   (pins_in[i]),
      .sync_o  (sync_w[i]),
      .stable_o(stable_w[i])
    );
  end

  assign unused_bus = &{1'b0, avs_write, avs_writedata};

`ifdef INPUT_PIO_EDGE_IRQ_EN
  localparam edge_type_e ETYPE = edge_type_e'(EDGE_TYPE[1:0]);

  logic [WIDTH-1:0] stable_dly_q, stable_dly_d;
  logic [WIDTH-1:0] edge_cap_q,   edge_cap_d;
  logic [WIDTH-1:0] irq_mask_q,   irq_mask_d;
  logic [WIDTH-1:0] edge_det;
  logic [WIDTH-1:0] w1c;
  logic             irq_q,        irq_d;

  // A new edge is OR-ed in after the clear so it survives a same-cycle W1C.
  always_comb begin
    stable_dly_d = stable_w;
    case (ETYPE)
      EDGE_RISE: edge_det = stable_w & ~stable_dly_q;
      EDGE_FALL: edge_det = ~stable_w & stable_dly_q;
      default:   edge_det = stable_w ^ stable_dly_q;
    endcase
    w1c = '0;
    if (avs_write && (avs_address == ADDR_EDGE_CAP)) begin
      w1c = avs_writedata[WIDTH-1:0];
    end
    irq_mask_d = irq_mask_q;
    if (avs_write && (avs_address == ADDR_IRQ_MASK)) begin
      irq_mask_d = avs_writedata[WIDTH-1:0];
    end
    edge_cap_d = (edge_cap_q & ~w1c) | edge_det;
    irq_d      = |(edge_cap_q & irq_mask_q);
  end

  always_ff @(posedge clk50 or negedge reset_n) begin
    if (!reset_n) begin
      stable_dly_q <= '0;
      edge_cap_q   <= '0;
      irq_mask_q   <= '0;
      irq_q        <= 1'b0;
    end else begin
      stable_dly_q <= stable_dly_d;
      edge_cap_q   <= edge_cap_d;
      irq_mask_q   <= irq_mask_d;
      irq_q        <= irq_d;
    end
  end

  assign irq = irq_q;
`else
  assign irq = 1'b0;
`endif

  // Read mux samples pre-write register values, so a same-cycle write is not visible.
  always_comb begin
    readdata_d = readdata_q;
    if (avs_read) begin
      readdata_d = '0;
      case (avs_address)
        ADDR_DATA:     readdata_d[WIDTH-1:0] = stable_w;
`ifdef INPUT_PIO_EDGE_IRQ_EN
        ADDR_IRQ_MASK: readdata_d[WIDTH-1:0] = irq_mask_q;
        ADDR_EDGE_CAP: readdata_d[WIDTH-1:0] = edge_cap_q;
`endif
        ADDR_RAW:      readdata_d[WIDTH-1:0] = sync_w;
        default:       readdata_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk50 or negedge reset_n) begin
    if (!reset_n) begin
      readdata_q <= '0;
    end else begin
      readdata_q <= readdata_d;
    end
  end

  assign avs_readdata = readdata_q;

endmodule
